// File: rtl/apb_arb_pkg.sv
// Shared FSM state encoding and default sizing for the APB master arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_AW             = 8;
    localparam int DEF_DW             = 8;
    localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Rotating-pointer picker: grants the first set request at or above ptr, wrapping at N.
module apb_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW:0] idx;

    // NOTE: every output gets a default before the loop, so no path can infer a latch.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = |req;
        idx       = '0;
        // Scan from the farthest offset down so the nearest request to ptr wins last.
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (IW + 1)'(k);
            if (idx >= (IW + 1)'(N)) begin
                idx = idx - (IW + 1)'(N);
            end
            if (req[idx[IW-1:0]]) begin
                grant_oh                 = '0;
                grant_oh[idx[IW-1:0]]    = 1'b1;
                grant_idx                = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master sharing one bus among NUM_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to abandon ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW
`ifdef APB_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [AW-1:0]         paddr,
    output logic [DW-1:0]         pwdata,
    input  logic [DW-1:0]         prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int IW = $clog2(NUM_REQ);

    apb_state_e         state_q;
    logic [IW-1:0]      ptr_q, ptr_d, owner_q, grant_idx;
    logic [NUM_REQ-1:0] grant_oh, rsp_valid_q;
    logic               any_req, accept;
    logic               psel_q, penable_q, pwrite_q, rsp_err_q;
    logic [AW-1:0]      paddr_q, sel_addr;
    logic [DW-1:0]      pwdata_q, rsp_rdata_q, sel_wdata;
    logic               sel_write;
`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]      tmo_q;
`endif

    apb_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    // Arbitration is open in IDLE and in the completing ACCESS cycle; gated by prst so
    // req_ready reads as its reset value while reset is asserted.
    assign accept    = any_req && !prst &&
                       ((state_q == ST_IDLE) || ((state_q == ST_ACCESS) && pready));
    assign req_ready = accept ? grant_oh : '0;
    assign ptr_d     = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // NOTE: sequential state uses non-blocking assignments only; the later accept
    // block deliberately overrides what the case statement scheduled.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    tmo_q     <= '0;
`endif
                end
                ST_ACCESS: begin
                    if (pready) begin
                        rsp_valid_q <= NUM_REQ'(1) << owner_q;
                        rsp_rdata_q <= pwrite_q ? '0 : prdata;
                        rsp_err_q   <= pslverr;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else if (tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid_q <= NUM_REQ'(1) << owner_q;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                default: state_q <= ST_IDLE;
            endcase

            if (accept) begin
                pwrite_q  <= sel_write;
                paddr_q   <= sel_addr;
                pwdata_q  <= sel_wdata;
                owner_q   <= grant_idx;
                ptr_q     <= ptr_d;
                psel_q    <= 1'b1;
                penable_q <= 1'b0;
                state_q   <= ST_SETUP;
            end
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
